// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator, 800x600 @ 60 Hz (SVGA).
// Produces pixel coordinates, the visible-area flag and H/V sync.
// Optional build macro: VGA_TIMING_NEG_SYNC_EN makes both syncs active-low.
// All registered outputs are decoded from the next-state counters so every
// output describes the same pixel in the same cycle.

module vga_timing #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23
) (
    input  logic        CLK_PIXEL,
    input  logic        RST,
    output logic        VGA_HSYNC,
    output logic        VGA_VSYNC,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        on_screen
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

`ifdef VGA_TIMING_NEG_SYNC_EN
    localparam logic SYNC_ACTIVE = 1'b0;
`else
    localparam logic SYNC_ACTIVE = 1'b1;
`endif

    logic [10:0] x_next;
    logic [10:0] y_next;
    logic        hsync_next;
    logic        vsync_next;
    logic        on_screen_next;

    // Next raster position: x wraps at end of line, y advances on that wrap
    // and itself wraps at end of frame.
    always_comb begin
        x_next = pixel_x + 11'd1;
        y_next = pixel_y;
        if (pixel_x == H_LAST) begin
            x_next = 11'd0;
            if (pixel_y == V_LAST) begin
                y_next = 11'd0;
            end else begin
                y_next = pixel_y + 11'd1;
            end
        end
    end

    // Decode sync windows and visible area from the next position so the
    // registered flags line up with the registered counters.
    always_comb begin
        on_screen_next = (x_next < H_VIS_END) && (y_next < V_VIS_END);
        hsync_next     = ~SYNC_ACTIVE;
        vsync_next     = ~SYNC_ACTIVE;
        if ((x_next >= H_SYNC_START) && (x_next <= H_SYNC_LAST)) begin
            hsync_next = SYNC_ACTIVE;
        end
        if ((y_next >= V_SYNC_START) && (y_next <= V_SYNC_LAST)) begin
            vsync_next = SYNC_ACTIVE;
        end
    end

    // Counter and output registers; reset parks the raster at (0,0) with
    // syncs inactive and the visible flag low.
    always_ff @(posedge CLK_PIXEL or negedge RST) begin
        if (!RST) begin
            pixel_x   <= 11'd0;
            pixel_y   <= 11'd0;
            on_screen <= 1'b0;
            VGA_HSYNC <= ~SYNC_ACTIVE;
            VGA_VSYNC <= ~SYNC_ACTIVE;
        end else begin
            pixel_x   <= x_next;
            pixel_y   <= y_next;
            on_screen <= on_screen_next;
            VGA_HSYNC <= hsync_next;
            VGA_VSYNC <= vsync_next;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing. Horizontal timing uses the
// real SVGA values; the vertical geometry is shrunk so that whole frames fit
// in a short run while keeping the same window/wrap structure.
// Honours VGA_TIMING_NEG_SYNC_EN for the expected sync levels.

module tb_vga_timing;

    localparam int V_VIS = 20;
    localparam int V_FR  = 1;
    localparam int V_SY  = 4;
    localparam int V_BK  = 3;
    localparam int LINE  = 1056;
    localparam int FRAME = LINE * (V_VIS + V_FR + V_SY + V_BK);

`ifdef VGA_TIMING_NEG_SYNC_EN
    localparam logic SYNC_ON = 1'b0;
`else
    localparam logic SYNC_ON = 1'b1;
`endif

    logic        CLK_PIXEL;
    logic        RST;
    logic        VGA_HSYNC;
    logic        VGA_VSYNC;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        on_screen;

    int compared;
    int mismatched;
    int edges;
    int hs_rise_count;
    int hs_rise_first;
    int hs_rise_second;
    int vs_active_count;
    logic prev_hs;

    typedef struct {
        int   frame;
        int   x;
        int   y;
        logic on;
        logic hs;
        logic vs;
    } vec_t;

    vec_t vecs[19];

    vga_timing #(
        .H_VISIBLE(800),
        .H_FRONT  (40),
        .H_SYNC   (128),
        .H_BACK   (88),
        .V_VISIBLE(V_VIS),
        .V_FRONT  (V_FR),
        .V_SYNC   (V_SY),
        .V_BACK   (V_BK)
    ) dut (
        .CLK_PIXEL(CLK_PIXEL),
        .RST      (RST),
        .VGA_HSYNC(VGA_HSYNC),
        .VGA_VSYNC(VGA_VSYNC),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .on_screen(on_screen)
    );

    // 40 MHz-style free-running pixel clock (period 10 time units)
    initial begin
        CLK_PIXEL = 1'b0;
        forever #5 CLK_PIXEL = ~CLK_PIXEL;
    end

    // Compare one value and report it when it differs
    task automatic check_output(input string name, input logic [10:0] act,
                                input logic [10:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge, sample 1 unit later, track sync measurements
    task automatic step_clock();
        @(posedge CLK_PIXEL);
        #1;
        edges++;
        if (VGA_HSYNC === SYNC_ON && prev_hs !== SYNC_ON) begin
            if (hs_rise_count == 0) hs_rise_first = edges;
            else if (hs_rise_count == 1) hs_rise_second = edges;
            hs_rise_count++;
        end
        prev_hs = VGA_HSYNC;
        if (VGA_VSYNC === SYNC_ON) vs_active_count++;
    endtask

    // Run until the given number of edges since reset release
    task automatic apply_stimulus(input int target);
        while (edges < target) step_clock();
    endtask

    // Check the full output set against a reset-state expectation
    task automatic check_reset(input string tag);
        check_output({tag, "_x"},  pixel_x,   11'd0);
        check_output({tag, "_y"},  pixel_y,   11'd0);
        check_output({tag, "_on"}, {10'd0, on_screen}, 11'd0);
        check_output({tag, "_hs"}, {10'd0, VGA_HSYNC}, {10'd0, ~SYNC_ON});
        check_output({tag, "_vs"}, {10'd0, VGA_VSYNC}, {10'd0, ~SYNC_ON});
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        edges           = 0;
        hs_rise_count   = 0;
        hs_rise_first   = 0;
        hs_rise_second  = 0;
        vs_active_count = 0;
        prev_hs         = ~SYNC_ON;

        vecs[0]  = '{0,    1,  0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0,  799,  0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{0,  800,  0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{0,  839,  0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{0,  840,  0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{0,  967,  0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{0,  968,  0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{0, 1055,  0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{0,    0,  1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{0,  799, 19, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{0,    0, 20, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{0,  100, 20, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{0,    0, 21, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{0,  900, 22, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{0, 1055, 24, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{0,    0, 25, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{0, 1055, 27, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1,    0,  0, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1,    1,  0, 1'b1, 1'b0, 1'b0};

        // Power-on reset
        RST = 1'b0;
        #12;
        check_reset("por");
        @(negedge CLK_PIXEL);
        RST = 1'b1;

        // Table-driven sweep across the first frame and its wrap
        for (int i = 0; i < 19; i++) begin
            apply_stimulus(vecs[i].frame * FRAME + vecs[i].y * LINE + vecs[i].x);
            check_output($sformatf("v%0d_x", i),  pixel_x, 11'(vecs[i].x));
            check_output($sformatf("v%0d_y", i),  pixel_y, 11'(vecs[i].y));
            check_output($sformatf("v%0d_on", i), {10'd0, on_screen},
                         {10'd0, vecs[i].on});
            check_output($sformatf("v%0d_hs", i), {10'd0, VGA_HSYNC},
                         {10'd0, vecs[i].hs ? SYNC_ON : ~SYNC_ON});
            check_output($sformatf("v%0d_vs", i), {10'd0, VGA_VSYNC},
                         {10'd0, vecs[i].vs ? SYNC_ON : ~SYNC_ON});
        end

        // HSYNC period and VSYNC duration over the first frame
        check_output("hs_rises_seen", {10'd0, hs_rise_count >= 2}, 11'd1);
        check_output("hs_period", 11'(hs_rise_second - hs_rise_first), 11'(LINE));
        compared++;
        if (vs_active_count != V_SY * LINE) begin
            mismatched++;
            $display("[TB] FAIL vs_duration: got %0d, expected %0d",
                     vs_active_count, V_SY * LINE);
        end

        // Mid-frame asynchronous reset at (400,10)
        apply_stimulus(FRAME + 10 * LINE + 400);
        check_output("pre_rst_x", pixel_x, 11'd400);
        check_output("pre_rst_y", pixel_y, 11'd10);
        check_output("pre_rst_on", {10'd0, on_screen}, 11'd1);
        #2;
        RST = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge CLK_PIXEL);
        RST = 1'b1;
        step_clock();
        check_output("resume_x", pixel_x, 11'd1);
        check_output("resume_y", pixel_y, 11'd0);
        check_output("resume_on", {10'd0, on_screen}, 11'd1);
        check_output("resume_hs", {10'd0, VGA_HSYNC}, {10'd0, ~SYNC_ON});
        check_output("resume_vs", {10'd0, VGA_VSYNC}, {10'd0, ~SYNC_ON});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
